// File: rtl/atm_session_driver_pkg.sv
// Shared types and constants for the ATM session driver: FSM state
// encoding, response status codes, operation codes and pin-level widths.
package atm_session_driver_pkg;

   localparam int PIN_W  = 4;
   localparam int OP_W   = 2;
   localparam int WD_W   = 6;
   localparam int DEP_W  = 5;
   localparam int STAT_W = 2;

   // Operation codes carried on cmd_op / Operation
   localparam logic [OP_W-1:0] OP_WITHDRAW = 2'd0;
   localparam logic [OP_W-1:0] OP_DEPOSIT  = 2'd1;
   localparam logic [OP_W-1:0] OP_BALANCE  = 2'd2;
   localparam logic [OP_W-1:0] OP_EJECT    = 2'd3;

   // Response status codes carried on rsp_status
   localparam logic [STAT_W-1:0] ST_OK      = 2'd0;
   localparam logic [STAT_W-1:0] ST_EJECT   = 2'd1;
   localparam logic [STAT_W-1:0] ST_TIMEOUT = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_CARD     = 4'd1,
      S_LANG     = 4'd2,
      S_PIN      = 4'd3,
      S_WAIT_CMD = 4'd4,
      S_GOMAIN   = 4'd5,
      S_OP       = 4'd6,
      S_SAMPLE   = 4'd7,
      S_RESP     = 4'd8,
      S_EXIT     = 4'd9,
      S_TMO      = 4'd10
   } state_t;

   // States whose outputs are held for HOLD_CYCLES by the step timer
   function automatic logic is_drive_state(input state_t s);
      logic r;
      case (s)
         S_CARD, S_LANG, S_PIN, S_GOMAIN, S_OP, S_EXIT: r = 1'b1;
         default:                                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/atm_session_driver_if.sv
// Command / response handshake bundle between the host (keypad controller)
// and the ATM session driver. master = host side, slave = driver side.
interface atm_session_driver_if
   import atm_session_driver_pkg::*;
#(
   parameter int BAL_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [PIN_W-1:0]  cmd_pin;
   logic              cmd_lang;
   logic [OP_W-1:0]   cmd_op;
   logic [WD_W-1:0]   cmd_wd;
   logic [DEP_W-1:0]  cmd_dep;
   logic              cmd_more;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [BAL_W-1:0]  rsp_balance;
   logic [STAT_W-1:0] rsp_status;

   modport master (
      output cmd_valid, cmd_pin, cmd_lang, cmd_op, cmd_wd, cmd_dep, cmd_more, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_balance, rsp_status
   );

   modport slave (
      input  cmd_valid, cmd_pin, cmd_lang, cmd_op, cmd_wd, cmd_dep, cmd_more, rsp_ready,
      output cmd_ready, rsp_valid, rsp_balance, rsp_status
   );
endinterface

// File: rtl/atm_session_driver_hold_timer.sv
// Step timer: loadable down-counter. o_done is high in the cycle in which
// HOLD_CYCLES cycles have elapsed since the last load, then stays low until
// the next load.
module atm_session_driver_hold_timer #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   output logic o_done
);
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_run;

   // Load on step entry, count down, stop once the terminal count is seen
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= {CNT_W{1'b0}};
         r_run <= 1'b0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(HOLD_CYCLES - 1);
         r_run <= 1'b1;
      end else if (r_run) begin
         if (r_cnt == {CNT_W{1'b0}}) begin
            r_run <= 1'b0;
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end else begin
         r_cnt <= r_cnt;
         r_run <= r_run;
      end
   end

   assign o_done = r_run && (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/atm_session_driver.sv
// ATM session driver: customer-side initiator for MainModule. Accepts one
// command per handshake, steps MainModule's pin-level inputs through the
// card/language/PIN/operation sequence, samples FinalBalance and returns it
// on the response handshake.
// Optional feature macro: ATM_TIMEOUT_EN (idle-in-session timeout, Timer pulse).
// Pin-level outputs are registered from the current state, so each appears
// one cycle after its state is entered; cmd_ready/rsp_* are registered from
// the next state and line up with the state itself.
module atm_session_driver
   import atm_session_driver_pkg::*;
#(
   parameter int HOLD_CYCLES    = 2,
   parameter int BAL_W          = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   atm_session_driver_if.slave io_bus,
   output logic             o_card_in,
   output logic             o_language_chosen,
   output logic             o_leave,
   output logic             o_go_main,
   output logic             o_timer,
   output logic [PIN_W-1:0] o_pin,
   output logic [OP_W-1:0]  o_operation,
   output logic [WD_W-1:0]  o_withdraw_amount,
   output logic [DEP_W-1:0] o_deposit_amount,
   input  logic [BAL_W-1:0] i_final_balance
);

   state_t r_state;
   state_t w_next_state;

   logic              w_accept;
   logic              w_hold_load;
   logic              w_hold_done;
   logic              w_tmo_hit;

   logic [PIN_W-1:0]  r_cmd_pin;
   logic              r_cmd_lang;
   logic [OP_W-1:0]   r_cmd_op;
   logic [WD_W-1:0]   r_cmd_wd;
   logic [DEP_W-1:0]  r_cmd_dep;
   logic              r_cmd_more;

   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [STAT_W-1:0] r_status;
   logic [BAL_W-1:0]  r_bal;

   logic              r_card_in;
   logic              r_lang_out;
   logic              r_leave;
   logic              r_go_main;
   logic [PIN_W-1:0]  r_pin_out;
   logic [OP_W-1:0]   r_op_out;
   logic [WD_W-1:0]   r_wd_out;
   logic [DEP_W-1:0]  r_dep_out;

   assign w_accept    = io_bus.cmd_valid && r_cmd_ready;
   assign w_hold_load = (w_next_state != r_state) && is_drive_state(w_next_state);

   atm_session_driver_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_hold_load),
      .o_done (w_hold_done)
   );

`ifdef ATM_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_timer;

   // A command accepted on the terminal count wins over the timeout
   assign w_tmo_hit = (r_state == S_WAIT_CMD) && !w_accept &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Idle counter: runs only while waiting in session, cleared otherwise
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end else if ((r_state == S_WAIT_CMD) && !w_accept && !w_tmo_hit) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end
   end

   // Timer pulse to MainModule for the single cycle spent in the timeout state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_timer <= 1'b0;
      end else begin
         r_timer <= (r_state == S_TMO);
      end
   end

   assign o_timer = r_timer;
`else
   assign w_tmo_hit = 1'b0;
   assign o_timer   = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: drive states advance on the step timer
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = S_CARD;
            else          w_next_state = S_IDLE;
         end
         S_CARD: begin
            if (w_hold_done) w_next_state = S_LANG;
            else             w_next_state = S_CARD;
         end
         S_LANG: begin
            if (w_hold_done) w_next_state = S_PIN;
            else             w_next_state = S_LANG;
         end
         S_PIN: begin
            if (w_hold_done) w_next_state = S_OP;
            else             w_next_state = S_PIN;
         end
         S_WAIT_CMD: begin
            if (w_accept)       w_next_state = S_GOMAIN;
            else if (w_tmo_hit) w_next_state = S_TMO;
            else                w_next_state = S_WAIT_CMD;
         end
         S_GOMAIN: begin
            if (w_hold_done) w_next_state = S_OP;
            else             w_next_state = S_GOMAIN;
         end
         S_OP: begin
            if (!w_hold_done)               w_next_state = S_OP;
            else if (r_cmd_op == OP_EJECT)  w_next_state = S_RESP;
            else                            w_next_state = S_SAMPLE;
         end
         S_SAMPLE: begin
            w_next_state = S_RESP;
         end
         S_RESP: begin
            if (!io_bus.rsp_ready)                          w_next_state = S_RESP;
            else if ((r_status == ST_OK) && r_cmd_more)     w_next_state = S_WAIT_CMD;
            else                                            w_next_state = S_EXIT;
         end
         S_EXIT: begin
            if (w_hold_done) w_next_state = S_IDLE;
            else             w_next_state = S_EXIT;
         end
         S_TMO: begin
            w_next_state = S_RESP;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Command capture: PIN and language only when opening a new session
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cmd_pin  <= {PIN_W{1'b0}};
         r_cmd_lang <= 1'b0;
         r_cmd_op   <= {OP_W{1'b0}};
         r_cmd_wd   <= {WD_W{1'b0}};
         r_cmd_dep  <= {DEP_W{1'b0}};
         r_cmd_more <= 1'b0;
      end else if (w_accept) begin
         if (r_state == S_IDLE) begin
            r_cmd_pin  <= io_bus.cmd_pin;
            r_cmd_lang <= io_bus.cmd_lang;
         end else begin
            r_cmd_pin  <= r_cmd_pin;
            r_cmd_lang <= r_cmd_lang;
         end
         r_cmd_op   <= io_bus.cmd_op;
         r_cmd_wd   <= io_bus.cmd_wd;
         r_cmd_dep  <= io_bus.cmd_dep;
         r_cmd_more <= io_bus.cmd_more;
      end else begin
         r_cmd_pin  <= r_cmd_pin;
         r_cmd_lang <= r_cmd_lang;
         r_cmd_op   <= r_cmd_op;
         r_cmd_wd   <= r_cmd_wd;
         r_cmd_dep  <= r_cmd_dep;
         r_cmd_more <= r_cmd_more;
      end
   end

   // Handshake outputs and response payload, aligned with the state they belong to
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_status    <= ST_OK;
         r_bal       <= {BAL_W{1'b0}};
      end else begin
         r_cmd_ready <= (w_next_state == S_IDLE) || (w_next_state == S_WAIT_CMD);
         r_rsp_valid <= (w_next_state == S_RESP);
         if (r_state == S_SAMPLE) begin
            r_bal <= i_final_balance;
         end else begin
            r_bal <= r_bal;
         end
         if ((w_next_state == S_RESP) && (r_state != S_RESP)) begin
            case (r_state)
               S_OP:    r_status <= ST_EJECT;
               S_TMO:   r_status <= ST_TIMEOUT;
               default: r_status <= ST_OK;
            endcase
         end else begin
            r_status <= r_status;
         end
      end
   end

   // MainModule pin-level drive: session values persist until back in IDLE
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_card_in  <= 1'b0;
         r_lang_out <= 1'b0;
         r_leave    <= 1'b0;
         r_go_main  <= 1'b0;
         r_pin_out  <= {PIN_W{1'b0}};
         r_op_out   <= {OP_W{1'b0}};
         r_wd_out   <= {WD_W{1'b0}};
         r_dep_out  <= {DEP_W{1'b0}};
      end else begin
         r_card_in <= (r_state != S_IDLE);
         r_go_main <= (r_state == S_GOMAIN);
         r_leave   <= (r_state == S_EXIT);
         case (r_state)
            S_IDLE: begin
               r_lang_out <= 1'b0;
               r_pin_out  <= {PIN_W{1'b0}};
               r_op_out   <= {OP_W{1'b0}};
               r_wd_out   <= {WD_W{1'b0}};
               r_dep_out  <= {DEP_W{1'b0}};
            end
            S_LANG: begin
               r_lang_out <= r_cmd_lang;
            end
            S_PIN: begin
               r_pin_out <= r_cmd_pin;
            end
            S_OP: begin
               r_op_out  <= r_cmd_op;
               r_wd_out  <= r_cmd_wd;
               r_dep_out <= r_cmd_dep;
            end
            default: begin
               r_lang_out <= r_lang_out;
               r_pin_out  <= r_pin_out;
               r_op_out   <= r_op_out;
               r_wd_out   <= r_wd_out;
               r_dep_out  <= r_dep_out;
            end
         endcase
      end
   end

   assign io_bus.cmd_ready   = r_cmd_ready;
   assign io_bus.rsp_valid   = r_rsp_valid;
   assign io_bus.rsp_balance = r_bal;
   assign io_bus.rsp_status  = r_status;

   assign o_card_in         = r_card_in;
   assign o_language_chosen = r_lang_out;
   assign o_leave           = r_leave;
   assign o_go_main         = r_go_main;
   assign o_pin             = r_pin_out;
   assign o_operation       = r_op_out;
   assign o_withdraw_amount = r_wd_out;
   assign o_deposit_amount  = r_dep_out;

endmodule

// File: tb/tb_atm_session_driver.sv
// Directed bench for atm_session_driver with HOLD_CYCLES=2, TIMEOUT_CYCLES=8.
// MainModule is stubbed as a constant FinalBalance. Cycle n counts rising
// edges after the accepting edge; everything is sampled on the falling edge.
module tb_atm_session_driver;
   import atm_session_driver_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       card_in, lang_chosen, leave, go_main, timer;
   logic [3:0] pin;
   logic [1:0] operation;
   logic [5:0] wd_amt;
   logic [4:0] dep_amt;
   logic [7:0] final_balance;

   int checks = 0;
   int errors = 0;
   int n = 0;
   int gm_cycles = 0;
   int leave_cycles = 0;
   int timer_cycles = 0;

   atm_session_driver_if #(.BAL_W(8)) bus ();

   atm_session_driver #(
      .HOLD_CYCLES    (2),
      .BAL_W          (8),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .io_bus            (bus),
      .o_card_in         (card_in),
      .o_language_chosen (lang_chosen),
      .o_leave           (leave),
      .o_go_main         (go_main),
      .o_timer           (timer),
      .o_pin             (pin),
      .o_operation       (operation),
      .o_withdraw_amount (wd_amt),
      .o_deposit_amount  (dep_amt),
      .i_final_balance   (final_balance)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      n++;
      if (go_main) gm_cycles++;
      if (leave)   leave_cycles++;
      if (timer)   timer_cycles++;
   endtask

   task automatic clr_counts();
      gm_cycles = 0;
      leave_cycles = 0;
      timer_cycles = 0;
   endtask

   // Offer a command, wait (bounded) for it to be taken; returns at n=0
   task automatic send_cmd(input logic [3:0] p, input logic l, input logic [1:0] op,
                           input logic [5:0] wd, input logic [4:0] dep, input logic more);
      int guard;
      guard = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_pin   = p;
      bus.cmd_lang  = l;
      bus.cmd_op    = op;
      bus.cmd_wd    = wd;
      bus.cmd_dep   = dep;
      bus.cmd_more  = more;
      while (!bus.cmd_ready && guard < 40) begin
         tick();
         guard++;
      end
      tick();
      bus.cmd_valid = 1'b0;
      n = 0;
   endtask

   task automatic wait_rsp();
      while (!bus.rsp_valid && n < 60) tick();
   endtask

   // After the response is consumed, wait (bounded) for the card to come out
   task automatic wait_idle();
      int guard;
      guard = 0;
      while (!(bus.cmd_ready && !card_in && !leave) && guard < 30) begin
         tick();
         guard++;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_pin = 4'd0; bus.cmd_lang = 1'b0; bus.cmd_op = 2'd0;
      bus.cmd_wd = 6'd0; bus.cmd_dep = 5'd0; bus.cmd_more = 1'b0; bus.rsp_ready = 1'b1;
      final_balance = 8'd42;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_outs", {card_in, lang_chosen, leave, go_main, timer, pin, operation, wd_amt, dep_amt}, 0);
      rst = 1'b0;
      tick();

      // 1: new session, balance enquiry, no continuation
      clr_counts();
      send_cmd(4'b1101, 1'b1, OP_BALANCE, 6'd0, 5'd0, 1'b0);
      chk("t1_card_n0", card_in, 1'b0);
      chk("t1_ready_busy", bus.cmd_ready, 1'b0);
      tick();
      chk("t1_card_n1", card_in, 1'b1);
      while (n < 3) tick();
      chk("t1_lang_n3", lang_chosen, 1'b1);
      while (n < 5) tick();
      chk("t1_pin_n5", pin, 4'b1101);
      while (n < 7) tick();
      chk("t1_op_n7", operation, 2'd2);
      wait_rsp();
      chk("t1_latency", n, 9);
      chk("t1_balance", bus.rsp_balance, 8'd42);
      chk("t1_status", bus.rsp_status, ST_OK);
      wait_idle();
      chk("t1_leave_cycles", leave_cycles, 2);
      chk("t1_idle_outs", {card_in, lang_chosen, leave, go_main, pin, operation}, 0);
      chk("t1_idle_ready", bus.cmd_ready, 1'b1);

      // 2: eject straight away; 'more' must not keep the card in
      clr_counts();
      send_cmd(4'b0110, 1'b0, OP_EJECT, 6'd0, 5'd0, 1'b1);
      wait_rsp();
      chk("t2_latency", n, 8);
      chk("t2_status", bus.rsp_status, ST_EJECT);
      wait_idle();
      chk("t2_gomain", gm_cycles, 0);
      chk("t2_leave_cycles", leave_cycles, 2);
      chk("t2_card_out", card_in, 1'b0);

      // 3: continued session, deposit of 5 after a balance enquiry
      clr_counts();
      send_cmd(4'b0011, 1'b0, OP_BALANCE, 6'd0, 5'd0, 1'b1);
      wait_rsp();
      chk("t3_first_latency", n, 9);
      tick();
      chk("t3_wait_ready", bus.cmd_ready, 1'b1);
      chk("t3_card_kept", card_in, 1'b1);
      send_cmd(4'b1111, 1'b1, OP_DEPOSIT, 6'd0, 5'd5, 1'b0);
      wait_rsp();
      chk("t3_cont_latency", n, 5);
      chk("t3_gomain_cycles", gm_cycles, 2);
      chk("t3_card_still", card_in, 1'b1);
      chk("t3_pin_kept", pin, 4'b0011);
      chk("t3_lang_kept", lang_chosen, 1'b0);
      chk("t3_operation", operation, 2'd1);
      chk("t3_deposit", dep_amt, 5'd5);
      chk("t3_status", bus.rsp_status, ST_OK);
      wait_idle();
      chk("t3_leave_cycles", leave_cycles, 2);

      // 4: response back-pressure with a different balance pattern
      clr_counts();
      final_balance = 8'hA5;
      bus.rsp_ready = 1'b0;
      send_cmd(4'b1000, 1'b1, OP_WITHDRAW, 6'd33, 5'd0, 1'b0);
      wait_rsp();
      chk("t4_latency", n, 9);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_hold_valid", bus.rsp_valid, 1'b1);
         chk("t4_hold_bal", bus.rsp_balance, 8'hA5);
         chk("t4_hold_status", bus.rsp_status, ST_OK);
         chk("t4_hold_ready0", bus.cmd_ready, 1'b0);
      end
      chk("t4_withdraw", wd_amt, 6'd33);
      bus.rsp_ready = 1'b1;
      final_balance = 8'd42;
      tick();
      chk("t4_released", bus.rsp_valid, 1'b0);
      wait_idle();
      chk("t4_idle_wd", wd_amt, 6'd0);

      // 5: reset while the PIN is being presented
      send_cmd(4'b1010, 1'b1, OP_BALANCE, 6'd0, 5'd0, 1'b0);
      while (n < 4) tick();
      chk("t5_lang_before", lang_chosen, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_outs", {card_in, lang_chosen, leave, go_main, pin, operation, bus.rsp_valid}, 0);
      chk("t5_rst_ready", bus.cmd_ready, 1'b1);
      send_cmd(4'b0101, 1'b0, OP_BALANCE, 6'd0, 5'd0, 1'b0);
      chk("t5_restart_n0", card_in, 1'b0);
      tick();
      chk("t5_restart_card", card_in, 1'b1);
      wait_rsp();
      chk("t5_restart_latency", n, 9);
      wait_idle();

`ifdef ATM_TIMEOUT_EN
      // 6a: idle in session for 8 cycles -> timeout
      clr_counts();
      send_cmd(4'b0111, 1'b1, OP_BALANCE, 6'd0, 5'd0, 1'b1);
      wait_rsp();
      chk("t6_first_latency", n, 9);
      tick();
      wait_rsp();
      chk("t6_tmo_cycle", n, 19);
      chk("t6_timer_now", timer, 1'b1);
      chk("t6_status", bus.rsp_status, ST_TIMEOUT);
      wait_idle();
      chk("t6_timer_cycles", timer_cycles, 1);
      chk("t6_leave_cycles", leave_cycles, 2);
      // 6b: accept on the terminal count -> no timeout
      clr_counts();
      send_cmd(4'b0111, 1'b1, OP_BALANCE, 6'd0, 5'd0, 1'b1);
      wait_rsp();
      tick();
      repeat (7) tick();
      send_cmd(4'b0000, 1'b0, OP_BALANCE, 6'd0, 5'd0, 1'b0);
      wait_rsp();
      chk("t6b_latency", n, 5);
      chk("t6b_status", bus.rsp_status, ST_OK);
      wait_idle();
      chk("t6b_no_timer", timer_cycles, 0);
`else
      chk("timer_never", timer_cycles, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
